// File: rtl/fsk_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsk_tx_sched                                                 |
// | Description : Transmit scheduler for the CRC-over-4FSK link. Round-robin   |
// |               arbitration between two requesters, capture of the granted  |
// |               16-bit codeword, LSB-first serialisation at one bit per      |
// |               2^PHASE_BITS clocks, and an idle guard gap between frames.  |
// | Ports       : clk_sys, reset (sync, active-high)                           |
// |               req0/code0/gnt0, req1/code1/gnt1 : requester handshake       |
// |               tx_bit, tx_valid, phase, sign_cnt, sign_clk : symbol timing  |
// |               busy, frame_done : frame status                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fsk_tx_sched #(
    parameter int PHASE_BITS = 8,
    parameter int GAP_SYMS   = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [15:0]           code0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [15:0]           code1,
    output logic                  gnt1,
    output logic                  tx_bit,
    output logic                  tx_valid,
    output logic [PHASE_BITS-1:0] phase,
    output logic [3:0]            sign_cnt,
    output logic                  sign_clk,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Guard gap length in clocks; the counter only has to reach length-1.
    localparam int c_GAP_CYCLES = GAP_SYMS * (2 ** PHASE_BITS);
    localparam int c_GAP_W      = (c_GAP_CYCLES > 1) ? $clog2(c_GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        c_GAP_W'((c_GAP_CYCLES > 0) ? (c_GAP_CYCLES - 1) : 0);
    localparam logic [PHASE_BITS-1:0] c_PHASE_MAX = '1;
    localparam logic [3:0]            c_SIGN_LAST = 4'd15;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [PHASE_BITS-1:0] r_phase;
    logic [3:0]            r_sign_cnt;
    logic [15:0]           r_shadow;
    logic                  r_last_grant;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_frame_done;

    logic w_pick0;
    logic w_pick1;
    logic w_grant;
    logic w_frame_end;
    logic w_gap_end;

    // Round robin: on contention the requester that did not win last time
    // is chosen. last_grant resets to 1 so requester 0 wins the first tie.
    assign w_pick0     = req0 & (~req1 | r_last_grant);
    assign w_pick1     = req1 & (~req0 | ~r_last_grant);
    assign w_grant     = (r_state == S_IDLE) & (w_pick0 | w_pick1);
    assign w_frame_end = (r_state == S_SEND) & (r_phase == c_PHASE_MAX) &
                         (r_sign_cnt == c_SIGN_LAST);
    assign w_gap_end   = (r_state == S_GAP) & (r_gap_cnt == c_GAP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick0 | w_pick1) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // With no guard gap the frame_done cycle is already IDLE and
                // may arbitrate, giving a one-cycle inter-frame spacing.
                if (w_frame_end) begin
                    w_state_nxt = (GAP_SYMS > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_sign_cnt   <= '0;
            r_shadow     <= '0;
            r_last_grant <= 1'b1;
            r_gap_cnt    <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt0       <= w_grant & w_pick0;
            r_gnt1       <= w_grant & w_pick1;
            r_frame_done <= w_frame_end;

            if (w_grant) begin
                r_shadow     <= w_pick0 ? code0 : code1;
                r_last_grant <= w_pick1;
            end

            // Phase and symbol index wrap naturally at their maxima, so the
            // frame_done cycle sees both back at zero.
            if (r_state == S_SEND) begin
                r_phase <= r_phase + 1'b1;
                if (r_phase == c_PHASE_MAX) begin
                    r_sign_cnt <= r_sign_cnt + 1'b1;
                end
            end else begin
                r_phase    <= '0;
                r_sign_cnt <= '0;
            end

            // The frame_done cycle is the first gap cycle (count 0).
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign tx_valid   = (r_state == S_SEND);
    assign tx_bit     = (r_state == S_SEND) ? r_shadow[r_sign_cnt] : 1'b0;
    assign phase      = r_phase;
    assign sign_cnt   = r_sign_cnt;
    assign sign_clk   = tx_valid & (r_phase == '0);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fsk_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fsk_tx_sched                                              |
// | Description : Directed self-checking bench for fsk_tx_sched. Instance a    |
// |               uses GAP_SYMS=1, instance b uses GAP_SYMS=0.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fsk_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Expected LSB-first bit sequence of 16'hA5C3, worked out by hand.
    int exp_seq [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    // Instance a: GAP_SYMS = 1
    logic        reset_a = 1'b1, req0_a = 1'b0, req1_a = 1'b0;
    logic [15:0] code0_a = '0, code1_a = '0;
    logic        gnt0_a, gnt1_a, tx_bit_a, tx_valid_a, sign_clk_a, busy_a, frame_done_a;
    logic [7:0]  phase_a;
    logic [3:0]  sign_cnt_a;

    // Instance b: GAP_SYMS = 0
    logic        reset_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
    logic [15:0] code0_b = '0, code1_b = '0;
    logic        gnt0_b, gnt1_b, tx_bit_b, tx_valid_b, sign_clk_b, busy_b, frame_done_b;
    logic [7:0]  phase_b;
    logic [3:0]  sign_cnt_b;

    fsk_tx_sched #(.PHASE_BITS(8), .GAP_SYMS(1)) dut_a (
        .clk_sys(clk), .reset(reset_a),
        .req0(req0_a), .code0(code0_a), .gnt0(gnt0_a),
        .req1(req1_a), .code1(code1_a), .gnt1(gnt1_a),
        .tx_bit(tx_bit_a), .tx_valid(tx_valid_a), .phase(phase_a),
        .sign_cnt(sign_cnt_a), .sign_clk(sign_clk_a), .busy(busy_a),
        .frame_done(frame_done_a)
    );

    fsk_tx_sched #(.PHASE_BITS(8), .GAP_SYMS(0)) dut_b (
        .clk_sys(clk), .reset(reset_b),
        .req0(req0_b), .code0(code0_b), .gnt0(gnt0_b),
        .req1(req1_b), .code1(code1_b), .gnt1(gnt1_b),
        .tx_bit(tx_bit_b), .tx_valid(tx_valid_b), .phase(phase_b),
        .sign_cnt(sign_cnt_b), .sign_clk(sign_clk_b), .busy(busy_b),
        .frame_done(frame_done_b)
    );

    // Advance one clock and sample 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        req0_a = 1'b1; req1_a = 1'b1; req0_b = 1'b1; req1_b = 1'b1;
        tick(); tick();
        vectors++;
        if ({gnt0_a, gnt1_a, tx_bit_a, tx_valid_a, sign_clk_a, busy_a, frame_done_a} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags_a: got %b expected 0000000",
                     {gnt0_a, gnt1_a, tx_bit_a, tx_valid_a, sign_clk_a, busy_a, frame_done_a});
        end
        vectors++;
        if (phase_a !== 8'd0 || sign_cnt_a !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_counters_a: got phase=%0d sign_cnt=%0d expected 0/0", phase_a, sign_cnt_a);
        end
        vectors++;
        if ({gnt0_b, gnt1_b, tx_bit_b, tx_valid_b, sign_clk_b, busy_b, frame_done_b} !== 7'b0 ||
            phase_b !== 8'd0 || sign_cnt_b !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_all_b: got busy=%b tx_valid=%b phase=%0d expected 0/0/0",
                     busy_b, tx_valid_b, phase_b);
        end
        req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        vectors++;
        if (busy_a !== 1'b0 || gnt0_a !== 1'b0 || gnt1_a !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: got busy=%b gnt0=%b gnt1=%b expected 0/0/0", busy_a, gnt0_a, gnt1_a);
        end
    endtask

    task automatic test_single_frame();
        int unsigned start;
        int nprint;
        logic [7:0] ephase;
        logic [3:0] esign;
        nprint = 0;
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        req0_a = 1'b1; code0_a = 16'hA5C3;
        tick();
        // Change request inputs; the captured shadow must be unaffected.
        req0_a = 1'b0; code0_a = 16'h0000;
        start = cyc;
        vectors++;
        if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: got gnt0=%b gnt1=%b expected 1/0", gnt0_a, gnt1_a);
        end
        for (int i = 0; i < 4096; i++) begin
            ephase = 8'(i % 256);
            esign  = 4'(i / 256);
            vectors++;
            if (tx_valid_a !== 1'b1 || phase_a !== ephase || sign_cnt_a !== esign ||
                tx_bit_a !== 1'(exp_seq[i / 256]) || sign_clk_a !== (ephase == 8'd0) ||
                gnt0_a !== (i == 0) || frame_done_a !== 1'b0) begin
                miscompares++;
                if (nprint < 8) begin
                    nprint++;
                    $display("FAIL single_send_cycle %0d: got valid=%b phase=%0d sign=%0d bit=%b sclk=%b expected 1/%0d/%0d/%0d/%b",
                             i, tx_valid_a, phase_a, sign_cnt_a, tx_bit_a, sign_clk_a,
                             ephase, esign, exp_seq[i / 256], (ephase == 8'd0));
                end
            end
            tick();
        end
        vectors++;
        if (frame_done_a !== 1'b1 || (cyc - start) != 4096) begin
            miscompares++;
            $display("FAIL single_frame_done: got frame_done=%b at offset %0d expected 1 at 4096",
                     frame_done_a, cyc - start);
        end
        vectors++;
        if (tx_valid_a !== 1'b0 || tx_bit_a !== 1'b0 || busy_a !== 1'b1 ||
            phase_a !== 8'd0 || sign_cnt_a !== 4'd0) begin
            miscompares++;
            $display("FAIL single_done_cycle: got valid=%b bit=%b busy=%b phase=%0d sign=%0d expected 0/0/1/0/0",
                     tx_valid_a, tx_bit_a, busy_a, phase_a, sign_cnt_a);
        end
        tick();
        vectors++;
        if (frame_done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_pulse_width: got %b expected 0", frame_done_a);
        end
        repeat (254) tick();
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL single_gap_last: got busy=%b expected 1", busy_a);
        end
        tick();
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gap_end: got busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_contention();
        int gcnt, both;
        int gidx [3];
        int unsigned gcyc [3];
        logic gbit [3];
        gcnt = 0; both = 0;
        reset_a = 1'b1; req0_a = 1'b1; req1_a = 1'b1;
        code0_a = 16'h0001; code1_a = 16'h8000;
        tick(); tick();
        reset_a = 1'b0;
        for (int k = 0; k < 3 * 4353 + 20 && gcnt < 3; k++) begin
            tick();
            if (gnt0_a && gnt1_a) both++;
            else if (gnt0_a || gnt1_a) begin
                gidx[gcnt] = gnt1_a ? 1 : 0;
                gcyc[gcnt] = cyc;
                gbit[gcnt] = tx_bit_a;
                gcnt++;
            end
        end
        req0_a = 1'b0; req1_a = 1'b0;
        vectors++;
        if (gcnt != 3) begin
            miscompares++;
            $display("FAIL contention_grants: got %0d grants expected 3", gcnt);
        end else begin
            vectors++;
            if (gidx[0] != 0 || gidx[1] != 1 || gidx[2] != 0) begin
                miscompares++;
                $display("FAIL contention_order: got %0d,%0d,%0d expected 0,1,0", gidx[0], gidx[1], gidx[2]);
            end
            vectors++;
            if (gcyc[1] - gcyc[0] != 4353 || gcyc[2] - gcyc[1] != 4353) begin
                miscompares++;
                $display("FAIL contention_spacing: got %0d,%0d expected 4353,4353",
                         gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
            end
            vectors++;
            if (gbit[0] !== 1'b1 || gbit[1] !== 1'b0 || gbit[2] !== 1'b1) begin
                miscompares++;
                $display("FAIL contention_first_bit: got %b,%b,%b expected 1,0,1", gbit[0], gbit[1], gbit[2]);
            end
        end
        vectors++;
        if (both != 0) begin
            miscompares++;
            $display("FAIL contention_dual_grant: got %0d cycles expected 0", both);
        end
    endtask

    task automatic test_single_repeat();
        int n0, n1, nd;
        int unsigned dcyc [3];
        n0 = 0; n1 = 0; nd = 0;
        reset_a = 1'b1; tick();
        reset_a = 1'b0; req1_a = 1'b1; code1_a = 16'h1234;
        for (int k = 0; k < 3 * 4353 + 4200 && nd < 3; k++) begin
            tick();
            if (gnt0_a) n0++;
            if (gnt1_a) n1++;
            if (frame_done_a) begin
                dcyc[nd] = cyc;
                nd++;
            end
        end
        req1_a = 1'b0;
        vectors++;
        if (nd != 3) begin
            miscompares++;
            $display("FAIL repeat_done_count: got %0d expected 3", nd);
        end else begin
            vectors++;
            if (dcyc[1] - dcyc[0] != 4353 || dcyc[2] - dcyc[1] != 4353) begin
                miscompares++;
                $display("FAIL repeat_done_spacing: got %0d,%0d expected 4353,4353",
                         dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
            end
        end
        vectors++;
        if (n0 != 0 || n1 != 3) begin
            miscompares++;
            $display("FAIL repeat_grants: got gnt0=%0d gnt1=%0d expected 0/3", n0, n1);
        end
    endtask

    task automatic test_gap0();
        int unsigned s1;
        bit seen;
        reset_b = 1'b1; tick();
        reset_b = 1'b0; req0_b = 1'b1; code0_b = 16'hFFFF;
        seen = 0;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            if (gnt0_b) seen = 1;
        end
        s1 = cyc;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL gap0_first_grant: got none expected gnt0 within 5 cycles");
        end
        seen = 0;
        for (int k = 0; k < 4200 && !seen; k++) begin
            tick();
            if (frame_done_b) seen = 1;
        end
        vectors++;
        if (!seen || (cyc - s1) != 4096) begin
            miscompares++;
            $display("FAIL gap0_frame_done: got seen=%0d offset=%0d expected 1 at 4096", seen, cyc - s1);
        end
        vectors++;
        if (busy_b !== 1'b0 || tx_valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL gap0_done_busy: got busy=%b valid=%b expected 0/0", busy_b, tx_valid_b);
        end
        tick();
        vectors++;
        if (gnt0_b !== 1'b1 || tx_valid_b !== 1'b1 || (cyc - s1) != 4097) begin
            miscompares++;
            $display("FAIL gap0_regrant: got gnt0=%b valid=%b offset=%0d expected 1/1/4097",
                     gnt0_b, tx_valid_b, cyc - s1);
        end
        req0_b = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        int nd;
        nd = 0;
        reset_a = 1'b1; tick();
        reset_a = 1'b0; req0_a = 1'b1; code0_a = 16'h00FF;
        tick();
        req0_a = 1'b0;
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (sign_cnt_a == 4'd7 && phase_a == 8'd100) seen = 1;
            else tick();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midreset_reach: got sign=%0d phase=%0d expected 7/100", sign_cnt_a, phase_a);
        end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0; req0_a = 1'b1; req1_a = 1'b1;
        vectors++;
        if (tx_valid_a !== 1'b0 || phase_a !== 8'd0 || sign_cnt_a !== 4'd0 ||
            busy_a !== 1'b0 || frame_done_a !== 1'b0 || tx_bit_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got valid=%b phase=%0d sign=%0d busy=%b done=%b expected 0/0/0/0/0",
                     tx_valid_a, phase_a, sign_cnt_a, busy_a, frame_done_a);
        end
        tick();
        // Requester 0 won before reset; restored last_grant must favour it again.
        vectors++;
        if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_regrant: got gnt0=%b gnt1=%b expected 1/0", gnt0_a, gnt1_a);
        end
        req0_a = 1'b0; req1_a = 1'b0;
        for (int k = 0; k < 2300; k++) begin
            tick();
            if (frame_done_a) nd++;
        end
        vectors++;
        if (nd != 0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", nd);
        end
    endtask

    task automatic test_withdrawn();
        bit seen;
        int n1, nv;
        n1 = 0; nv = 0;
        reset_a = 1'b1; tick();
        reset_a = 1'b0; req0_a = 1'b1; code0_a = 16'h5555;
        tick();
        req0_a = 1'b0;
        seen = 0;
        for (int k = 0; k < 4200 && !seen; k++) begin
            tick();
            if (frame_done_a) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL withdrawn_frame_done: got none expected pulse within 4200 cycles");
        end
        req1_a = 1'b1; code1_a = 16'hFFFF;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (gnt1_a || gnt0_a) n1++;
            if (tx_valid_a) nv++;
        end
        req1_a = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (gnt1_a || gnt0_a) n1++;
            if (tx_valid_a) nv++;
        end
        vectors++;
        if (n1 != 0 || nv != 0) begin
            miscompares++;
            $display("FAIL withdrawn_activity: got grants=%0d valid_cycles=%0d expected 0/0", n1, nv);
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL withdrawn_idle: got busy=%b expected 0", busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_single_repeat();
        test_gap0();
        test_reset_mid_frame();
        test_withdrawn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
